// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that applies one set/reset/toggle/hold command per cycle to a shared flag bank.
// Optional saturating error counter: define SR_ARB_ERRCNT_EN to add the err_cnt output.
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAG  = 8,
    parameter int FIDX_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [FIDX_W*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]          gnt,
    output logic [NFLAG-1:0]         flags
`ifdef SR_ARB_ERRCNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a requester raises req with a stable {op, idx}; the command is
    // taken at the edge that raises gnt[i], and gnt[i] masks req[i] for one
    // cycle so a requester that is still dropping req cannot win twice.

    logic [1:0]        op_a  [NREQ];
    logic [FIDX_W-1:0] idx_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g]  = req_op[2*g +: 2];
        assign idx_a[g] = req_idx[FIDX_W*g +: FIDX_W];
    end

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   win_oh;
    logic              win_vld;
    logic [1:0]        win_op;
    logic [FIDX_W-1:0] win_idx;
    logic              win_in_rng;
    logic [NFLAG-1:0]  flags_nxt;
    logic [PTR_W:0]    cand_w;
    logic [PTR_W:0]    next_w;
    logic [PTR_W-1:0]  cand;

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        elig    = req & ~gnt;
        win_oh  = '0;
        win_vld = 1'b0;
        win_op  = 2'b00;
        win_idx = '0;
        ptr_nxt = ptr;
        cand_w  = '0;
        next_w  = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand_w >= (PTR_W+1)'(NREQ)) begin
                cand_w = cand_w - (PTR_W+1)'(NREQ);
            end
            cand = cand_w[PTR_W-1:0];
            if (!win_vld && elig[cand]) begin
                win_vld      = 1'b1;
                win_oh[cand] = 1'b1;
                win_op       = op_a[cand];
                win_idx      = idx_a[cand];
                next_w       = cand_w + (PTR_W+1)'(1);
                if (next_w >= (PTR_W+1)'(NREQ)) begin
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = next_w[PTR_W-1:0];
                end
            end
        end
    end

    // An out-of-range index still consumes the grant but touches no flag.
    always_comb begin
        win_in_rng = (int'(win_idx) < NFLAG);
        flags_nxt  = flags;
        for (int f = 0; f < NFLAG; f++) begin
            if (win_vld && win_in_rng && (int'(win_idx) == f)) begin
                case (win_op)
                    2'b01:   flags_nxt[f] = 1'b0;
                    2'b10:   flags_nxt[f] = 1'b1;
                    2'b11:   flags_nxt[f] = ~flags[f];
                    default: flags_nxt[f] = flags[f];
                endcase
            end
        end
    end

    // clr outranks arbitration: requests stay pending and ptr is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt   <= '0;
            flags <= '0;
            ptr   <= '0;
        end else if (clr) begin
            gnt   <= '0;
            flags <= '0;
        end else begin
            gnt   <= win_oh;
            flags <= flags_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef SR_ARB_ERRCNT_EN
    logic err_hit;

    assign err_hit = win_vld && ((win_op == 2'b00) || !win_in_rng);

    // Saturates at 255 and survives clr; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (!clr && err_hit && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_sr_flag_arbiter;

    localparam int NREQ   = 4;
    localparam int NFLAG  = 8;
    localparam int FIDX_W = 4;
    localparam int W      = 20;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [15:0] req_idx;
    logic [3:0]  gnt;
    logic [7:0]  flags;
    logic [7:0]  err_cnt;

    int total;
    int bad;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .FIDX_W(FIDX_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .req     (req),
        .req_op  (req_op),
        .req_idx (req_idx),
        .gnt     (gnt),
`ifdef SR_ARB_ERRCNT_EN
        .err_cnt (err_cnt),
`endif
        .flags   (flags)
    );

`ifndef SR_ARB_ERRCNT_EN
    assign err_cnt = 8'd0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        clr     = 1'b0;
        req     = '0;
        req_op  = '0;
        req_idx = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // directed vector table
    typedef struct {
        bit         rst;
        bit         clr;
        logic [3:0] req;
        logic [7:0] op;
        logic [15:0] idx;
        logic [3:0] egnt;
        logic [7:0] eflags;
        logic [7:0] eerr;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(bit r, bit c, logic [3:0] rq, logic [7:0] o, logic [15:0] x,
                                logic [3:0] eg, logic [7:0] ef, logic [7:0] ee);
        vec_t v;
        v.rst = r; v.clr = c; v.req = rq; v.op = o; v.idx = x;
        v.egnt = eg; v.eflags = ef; v.eerr = ee;
        return v;
    endfunction

    // reference model state
    int         m_ptr;
    bit [3:0]   m_gnt;
    bit [7:0]   m_flags;
    int         m_err;
    logic [W-1:0] exp_q[$];

    task automatic model_reset();
        m_ptr = 0; m_gnt = '0; m_flags = '0; m_err = 0;
    endtask

    // Winner = eligible requester with the smallest rotated distance from ptr.
    task automatic model_step(input bit c, input bit [3:0] r, input bit [7:0] o, input bit [15:0] x);
        int best;
        int bestd;
        int d;
        int ix;
        bit [1:0] op;
        if (c) begin
            m_flags = '0;
            m_gnt   = '0;
        end else begin
            best  = -1;
            bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (r[i] && !m_gnt[i]) begin
                    d = (i - m_ptr + NREQ) % NREQ;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            m_gnt = '0;
            if (best >= 0) begin
                m_gnt[best] = 1'b1;
                m_ptr = (best + 1) % NREQ;
                op = o[2*best +: 2];
                ix = int'(x[4*best +: 4]);
                if (ix < NFLAG) begin
                    if (op == 2'b01) m_flags[ix] = 1'b0;
                    else if (op == 2'b10) m_flags[ix] = 1'b1;
                    else if (op == 2'b11) m_flags[ix] = ~m_flags[ix];
                end
                if ((op == 2'b00 || ix >= NFLAG) && m_err < 255) m_err++;
            end
        end
        exp_q.push_back({m_gnt, m_flags, 8'(m_err)});
    endtask

    initial begin
        logic [W-1:0] e;
        int grants;

        total = 0;
        bad   = 0;

        // reset values
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_flags", 32'(flags), 32'h0);
`ifdef SR_ARB_ERRCNT_EN
        chk("reset_err", 32'(err_cnt), 32'h0);
`endif

        // single set, then ptr=3 shows through the next grant order
        tbl[0]  = mk(1, 0, 4'b0100, 8'h20, 16'h0500, 4'b0100, 8'h20, 8'd0);
        tbl[1]  = mk(0, 0, 4'b1011, 8'hAA, 16'h3210, 4'b1000, 8'h28, 8'd0);
        tbl[2]  = mk(0, 0, 4'b0011, 8'hAA, 16'h3210, 4'b0001, 8'h29, 8'd0);
        tbl[3]  = mk(0, 0, 4'b0010, 8'hAA, 16'h3210, 4'b0010, 8'h2B, 8'd0);
        tbl[4]  = mk(0, 0, 4'b0000, 8'hAA, 16'h3210, 4'b0000, 8'h2B, 8'd0);
        // all four from ptr=0
        tbl[5]  = mk(1, 0, 4'b1111, 8'hAA, 16'h3210, 4'b0001, 8'h01, 8'd0);
        tbl[6]  = mk(0, 0, 4'b1110, 8'hAA, 16'h3210, 4'b0010, 8'h03, 8'd0);
        tbl[7]  = mk(0, 0, 4'b1100, 8'hAA, 16'h3210, 4'b0100, 8'h07, 8'd0);
        tbl[8]  = mk(0, 0, 4'b1000, 8'hAA, 16'h3210, 4'b1000, 8'h0F, 8'd0);
        tbl[9]  = mk(0, 0, 4'b0000, 8'hAA, 16'h3210, 4'b0000, 8'h0F, 8'd0);
        // toggle, with req held through its grant cycle (masked)
        tbl[10] = mk(0, 0, 4'b0001, 8'h03, 16'h0003, 4'b0001, 8'h07, 8'd0);
        tbl[11] = mk(0, 0, 4'b0001, 8'h03, 16'h0003, 4'b0000, 8'h07, 8'd0);
        tbl[12] = mk(0, 0, 4'b0001, 8'h03, 16'h0003, 4'b0001, 8'h0F, 8'd0);
        tbl[13] = mk(0, 0, 4'b0000, 8'h03, 16'h0003, 4'b0000, 8'h0F, 8'd0);
        // fill to 0xFF, then clr collides with a request
        tbl[14] = mk(0, 0, 4'b0001, 8'h02, 16'h0004, 4'b0001, 8'h1F, 8'd0);
        tbl[15] = mk(0, 0, 4'b0010, 8'h08, 16'h0050, 4'b0010, 8'h3F, 8'd0);
        tbl[16] = mk(0, 0, 4'b0100, 8'h20, 16'h0600, 4'b0100, 8'h7F, 8'd0);
        tbl[17] = mk(0, 0, 4'b1000, 8'h80, 16'h7000, 4'b1000, 8'hFF, 8'd0);
        tbl[18] = mk(0, 1, 4'b0010, 8'h04, 16'h0000, 4'b0000, 8'h00, 8'd0);
        tbl[19] = mk(0, 0, 4'b0010, 8'h04, 16'h0000, 4'b0010, 8'h00, 8'd0);
        tbl[20] = mk(0, 0, 4'b0000, 8'h04, 16'h0000, 4'b0000, 8'h00, 8'd0);
        // out-of-range index, then hold op
        tbl[21] = mk(0, 0, 4'b0001, 8'h02, 16'h0009, 4'b0001, 8'h00, 8'd1);
        tbl[22] = mk(0, 0, 4'b0010, 8'h00, 16'h0020, 4'b0010, 8'h00, 8'd2);
        tbl[23] = mk(0, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 8'h00, 8'd2);

        for (int v = 0; v < 24; v++) begin
            if (tbl[v].rst) do_reset();
            clr     = tbl[v].clr;
            req     = tbl[v].req;
            req_op  = tbl[v].op;
            req_idx = tbl[v].idx;
            tick();
            chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(tbl[v].egnt));
            chk($sformatf("vec%0d_flags", v), 32'(flags), 32'(tbl[v].eflags));
`ifdef SR_ARB_ERRCNT_EN
            chk($sformatf("vec%0d_err", v), 32'(err_cnt), 32'(tbl[v].eerr));
`endif
        end
        clr = 1'b0;

        // async reset between edges
        do_reset();
        req = 4'b1100; req_op = 8'hA0; req_idx = 16'h3200;
        tick();
        chk("arst_pre_gnt", 32'(gnt), 32'h4);
        chk("arst_pre_flags", 32'(flags), 32'h04);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_flags", 32'(flags), 32'h0);
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_after_gnt", 32'(gnt), 32'h8);
        chk("arst_after_flags", 32'(flags), 32'h08);

        // 300 hold-op grants saturate the error counter
        do_reset();
        grants = 0;
        req_op = 8'h00; req_idx = 16'h0022;
        for (int k = 0; k < 300; k++) begin
            req = k[0] ? 4'b0010 : 4'b0001;
            tick();
            if (gnt == req) grants++;
`ifdef SR_ARB_ERRCNT_EN
            if (k == 99)  chk("sat_err_100", 32'(err_cnt), 32'd100);
            if (k == 254) chk("sat_err_255", 32'(err_cnt), 32'd255);
`endif
        end
        req = '0;
        chk("sat_grants", 32'(grants), 32'd300);
        chk("sat_flags", 32'(flags), 32'h0);
`ifdef SR_ARB_ERRCNT_EN
        chk("sat_err_final", 32'(err_cnt), 32'd255);
`endif

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            model_step(clr, req, req_op, req_idx);
            tick();
            e = exp_q.pop_front();
            chk("rand_gnt", 32'(gnt), 32'(e[19:16]));
            chk("rand_flags", 32'(flags), 32'(e[15:8]));
`ifdef SR_ARB_ERRCNT_EN
            chk("rand_err", 32'(err_cnt), 32'(e[7:0]));
`endif
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]              = 1'b1;
                    req_op[2*i +: 2]    = 2'($urandom_range(0, 3));
                    req_idx[4*i +: 4]   = 4'($urandom_range(0, 10));
                end
            end
            clr = ($urandom_range(0, 15) == 0);
        end
        clr = 1'b0;
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin arbiter and sequencer for a shared bank of SR-style flag bits. NREQ requesters each issue a set/reset/toggle/hold command against one flag index. The block grants at most one requester per clock and applies the winning command to the flag bank. The illegal S=R=1 condition of a raw SR flip-flop is resolved as a defined toggle. It sits between control FSMs that post status events and the consumers that read `flags`.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NFLAG`, 8, number of flag bits (1..32)
- `FIDX_W`, 3, flag index width; the integrator sets it to at least clog2(NFLAG)

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `clr` input 1: synchronous clear of all flags.
- `req` input NREQ: request per requester; level, held until granted.
- `req_op` input 2*NREQ: per-requester `{S,R}`. `00` hold, `01` reset, `10` set, `11` toggle.
- `req_idx` input FIDX_W*NREQ: per-requester flag index.
- `gnt` output NREQ: one-hot grant, registered, one-cycle pulse.
- `flags` output NFLAG: flag bank state, registered.
- `err_cnt` output 8: present only with `SR_ARB_ERRCNT_EN`.

## Operation
- Eligible requesters are those with `req[i]` high, masked by `gnt[i]` currently high. This mask prevents a double grant while the requester drops `req`.
- Round-robin pointer `ptr`: the eligible requester at or after `ptr`, in ascending index with wrap, wins.
- On a grant to requester i: `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- Winner's command is applied to `flags[req_idx]` at the same edge that raises `gnt[i]`:
  - `01` clears the flag.
  - `10` sets the flag.
  - `11` inverts the flag.
  - `00` leaves the flag unchanged but still consumes a grant.
- If `req_idx` is greater than or equal to NFLAG, the requester is still granted and no flag changes.
- `clr` high at an edge:
  - All flags become 0.
  - No grant is issued that cycle; `gnt` is all 0 next cycle.
  - `ptr` holds.
  - Pending requests remain pending.
- Requester obligation:
  - Hold `req`, `req_op` and `req_idx` stable from assertion until `gnt[i]` is seen.
  - Drop `req` in the cycle `gnt[i]` is high, or re-present a new command no earlier than the following cycle.
  - Changing `req_op` or `req_idx` before the grant is undefined usage.
- Only one flag changes per cycle. No other write path to `flags` exists.

## Timing
- Reset (`rst_n` low, takes effect immediately):
  - `gnt` = 0, `flags` = 0, `ptr` = 0, `err_cnt` = 0.
- Reset mid-operation: all in-flight state is lost. After release, still-asserted requests re-arbitrate from `ptr` = 0 at the first rising edge.
- Latency: `req` sampled high at edge N gives `gnt` high and the updated `flags` visible after edge N. That is one cycle, when the requester wins.
- Throughput: one grant per cycle.
- Worst-case wait with all requesters continuously active is NREQ cycles. Because of the masking rule, a requester that re-requests immediately waits at least one extra cycle.
- Simultaneous `clr` and requests: `clr` wins and requests wait.
- Simultaneous `rst_n` assertion and a clock edge: reset wins.

## Configuration
- `SR_ARB_ERRCNT_EN` defined:
  - Adds output `err_cnt`, an 8-bit counter that saturates at 255.
  - It increments on each grant whose op is `00` or whose `req_idx` is out of range (at most +1 per grant).
  - It is cleared only by `rst_n`; `clr` does not clear it.
- Not defined: `err_cnt` port and logic are absent; all other behaviour is identical.

## Test plan
- Reset and single set:
  - Release `rst_n`, then req[2]=1, op=`10`, idx=5.
  - Next cycle: gnt=`0100`, flags=`0x20`.
  - After the grant: ptr=3.
- All four requesting together, each with op=`10` and idx=i, from ptr=0:
  - Grants in order `0001`, `0010`, `0100`, `1000` on consecutive cycles as each requester drops `req`.
  - Final flags=`0x0F`.
- Toggle resolution:
  - Flag 3 = 1, then req[0] op=`11` idx=3 gives flag 3 = 0.
  - Repeating it gives flag 3 = 1.
- Clear collision:
  - flags=`0xFF`, clr=1 together with req[1] op=`01` idx=0.
  - Next cycle: flags=`0x00`, gnt=0.
  - Cycle after: gnt=`0010`, flags still `0x00`.
- Out-of-range and hold ops (NFLAG=6, macro defined):
  - req[0] op=`10` idx=7, then req[1] op=`00` idx=2.
  - Both are granted, flags are unchanged, err_cnt=2.
  - 300 such grants give err_cnt=255.
- Async reset mid-stream:
  - Drop `rst_n` between edges while gnt=`0100`.
  - gnt and flags go to 0 immediately.
  - After release with req[3] held: first grant is `1000`.
